counter_seq_ctrl: RTL

- Sequencer for the 8-bit loadable up-counter (counter_8bit: ports clr, clk, l, s_s, c, d).
- Drives the counter's load, run and preset inputs and watches its count output.
- Runs a programmed count window start_val→end_val for repeat_cnt passes, then pulses done.
- Sits between a command source (host regs or test FSM) and one counter_8bit instance; both share clk and clr.

---
 rtl/counter_seq_ctrl_pkg.sv | 14 +
 rtl/counter_seq_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// rtl/counter_seq_ctrl_pkg.sv - shared state encoding and default widths for the counter sequencer
package counter_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RPT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - sequences an external loadable up-counter through a start..end window for N passes
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RPT_W = DEF_RPT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic [RPT_W-1:0] repeat_cnt,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_load,
  output logic             cnt_run,
  output logic [WIDTH-1:0] cnt_d,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [RPT_W-1:0] pass_cnt
);

  seq_state_e       state, state_nxt;
  logic [WIDTH-1:0] start_reg, end_reg;
  logic [RPT_W-1:0] rpt_reg;
  logic [RPT_W-1:0] pass_next;
  logic             aborted_q;
  logic             at_end;
  logic             abort_take;
  logic             pass_inc;

  assign at_end     = (cnt_q == end_reg);
  assign abort_take = abort && (state != ST_IDLE);
  assign pass_next  = pass_cnt + 1'b1;

  assign busy    = (state != ST_IDLE);
  assign cnt_d   = busy ? start_reg : '0;
  assign aborted = aborted_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      start_reg <= '0;
      end_reg   <= '0;
      rpt_reg   <= '0;
      pass_cnt  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      aborted_q <= abort_take;
      if (state == ST_IDLE && start) begin
        start_reg <= start_val;
        end_reg   <= end_val;
        rpt_reg   <= (repeat_cnt == '0) ? {{(RPT_W-1){1'b0}}, 1'b1} : repeat_cnt;
        pass_cnt  <= '0;
      end else if (pass_inc) begin
        pass_cnt <= pass_next;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_run   = 1'b0;
    done      = 1'b0;
    pass_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_load  = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // run is gated by the live compare so the counter stops exactly on end_reg
        cnt_run = !at_end;
        if (at_end) begin
          pass_inc  = 1'b1;
          state_nxt = (pass_next == rpt_reg) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // abort wins over everything, including a completing pass
    if (abort_take) begin
      state_nxt = ST_IDLE;
      cnt_load  = 1'b0;
      cnt_run   = 1'b0;
      done      = 1'b0;
      pass_inc  = 1'b0;
    end
  end

endmodule
